// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-side initiator for the byte-wide system memory bus.
//
// Turns word/half/byte requests from instruction fetch (IF) and load/store
// (LS) into a sequence of single-byte bus cycles and reassembles read data
// little-endian. LS wins over IF when both are pending in IDLE.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   rdy_in               1 = bus owned by the cpu, 0 = freeze
//   mem_din              read byte, valid the cycle after its address
//   mem_dout/mem_a/mem_wr  byte bus outputs (all zero outside issue cycles)
//   clear_in             pipeline flush (aborts reads, never stores)
//   if_*                 fetch request/response (always a 4-byte read)
//   ls_*                 load/store request/response (1, 2 or 4 bytes)
//   dbg_state_out        current FSM state (0 IDLE, 1 IF_READ, 2 LS_READ, 3 LS_WRITE)
//
// Handshake: a requester raises *_valid_in with its fields stable and holds
// them until its *_done_out pulse (exactly one cycle). The request is latched
// at the edge that leaves IDLE; data outputs hold until the next completion.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  clear_in,
  input  logic                  if_valid_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_valid_in,
  input  logic                  ls_wr_in,
  input  logic [1:0]            ls_size_in,
  input  logic [ADDR_WIDTH-1:0] ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  output logic [1:0]            dbg_state_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_READ  = 2'd1,
    LS_READ  = 2'd2,
    LS_WRITE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            len_q, len_d;      // bytes in this transfer: 1, 2 or 4
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            iss_q, iss_d;      // index of the byte on the bus now
  logic [2:0]            cap_q, cap_d;      // bytes captured (read) / written
  logic                  cap_vld_q, cap_vld_d; // mem_din carries byte cap_q
  logic                  stall_q;           // previous cycle had rdy_in = 0
  logic [31:0]           rbuf_q, rbuf_d;
  logic                  if_done_q, if_done_d;
  logic                  ls_done_q, ls_done_d;
  logic                  ls_done_wr_q, ls_done_wr_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;

  logic                  busy;
  logic                  is_rd;
  logic [2:0]            eff_iss;
  logic                  issuing;
  logic                  capture;
  logic                  rd_last;
  logic                  wr_last;
  logic                  accept_ls;
  logic                  accept_if;
  logic [31:0]           rbuf_nxt;
  logic [2:0]            ls_len;

  assign busy  = (state_q != IDLE);
  assign is_rd = (state_q == IF_READ) || (state_q == LS_READ);

  // Any byte issued while the bus belonged to HCI is untrustworthy, so the
  // first owned cycle after a freeze restarts from the first byte not yet
  // captured (reads) or not yet written with rdy_in high (writes).
  assign eff_iss = (stall_q && rdy_in) ? cap_q : iss_q;
  assign issuing = busy && (eff_iss < len_q);

  // The stale mem_din seen right after a freeze is never sampled.
  assign capture = is_rd && rdy_in && cap_vld_q && !stall_q;
  assign rd_last = capture && (cap_q == (len_q - 3'd1));
  assign wr_last = (state_q == LS_WRITE) && rdy_in && issuing &&
                   (eff_iss == (len_q - 3'd1));

  // A requester whose done pulse is showing still has valid high this cycle;
  // it must not be accepted a second time.
  assign accept_ls = (state_q == IDLE) && rdy_in && !clear_in &&
                     ls_valid_in && !ls_done_q;
  assign accept_if = (state_q == IDLE) && rdy_in && !clear_in &&
                     if_valid_in && !if_done_q && !accept_ls;

  always_comb begin
    ls_len = 3'd4;
    case (ls_size_in)
      2'd0:    ls_len = 3'd1;
      2'd1:    ls_len = 3'd2;
      default: ls_len = 3'd4;
    endcase
  end

  always_comb begin
    rbuf_nxt = rbuf_q;
    if (capture) rbuf_nxt[{cap_q[1:0], 3'b000} +: 8] = mem_din;
  end

  // Bus outputs. During a freeze they keep showing the held byte, but the
  // write strobe is dropped; reset also drops it so an aborted store cannot
  // land one more byte in the reset cycle.
  assign mem_a    = issuing ? (base_q + {{(ADDR_WIDTH-3){1'b0}}, eff_iss}) : '0;
  assign mem_wr   = issuing && (state_q == LS_WRITE) && rdy_in && !rst_in;
  assign mem_dout = (issuing && (state_q == LS_WRITE)) ?
                    wdata_q[{eff_iss[1:0], 3'b000} +: 8] : 8'h00;

  // A flush coinciding with a done pulse hides it, except for a completed store.
  assign if_done_out   = if_done_q && !clear_in;
  assign ls_done_out   = ls_done_q && (ls_done_wr_q || !clear_in);
  assign if_data_out   = if_data_q;
  assign ls_rdata_out  = ls_rdata_q;
  assign dbg_state_out = state_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    iss_d        = iss_q;
    cap_d        = cap_q;
    cap_vld_d    = cap_vld_q;
    rbuf_d       = rbuf_q;
    if_done_d    = 1'b0;
    ls_done_d    = 1'b0;
    ls_done_wr_d = ls_done_wr_q;
    if_data_d    = if_data_q;
    ls_rdata_d   = ls_rdata_q;

    // With rdy_in low everything holds; only the done pulses still expire.
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (accept_ls) begin
            state_d   = ls_wr_in ? LS_WRITE : LS_READ;
            base_d    = ls_addr_in;
            len_d     = ls_len;
            wdata_d   = ls_wdata_in;
            iss_d     = 3'd0;
            cap_d     = 3'd0;
            cap_vld_d = 1'b0;
            rbuf_d    = 32'h0;
          end else if (accept_if) begin
            state_d   = IF_READ;
            base_d    = if_addr_in;
            len_d     = 3'd4;
            iss_d     = 3'd0;
            cap_d     = 3'd0;
            cap_vld_d = 1'b0;
            rbuf_d    = 32'h0;
          end
        end

        IF_READ, LS_READ: begin
          if (clear_in) begin
            state_d   = IDLE;
            cap_vld_d = 1'b0;
          end else begin
            rbuf_d    = rbuf_nxt;
            iss_d     = eff_iss + {2'b00, issuing};
            cap_vld_d = issuing;
            if (capture) cap_d = cap_q + 3'd1;
            if (rd_last) begin
              state_d = IDLE;
              if (state_q == IF_READ) begin
                if_done_d = 1'b1;
                if_data_d = rbuf_nxt;
              end else begin
                ls_done_d    = 1'b1;
                ls_done_wr_d = 1'b0;
                ls_rdata_d   = rbuf_nxt;
              end
            end
          end
        end

        LS_WRITE: begin
          if (issuing) begin
            iss_d = eff_iss + 3'd1;
            cap_d = eff_iss + 3'd1;
          end
          if (wr_last) begin
            state_d      = IDLE;
            ls_done_d    = 1'b1;
            ls_done_wr_d = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= 3'd0;
      wdata_q      <= 32'h0;
      iss_q        <= 3'd0;
      cap_q        <= 3'd0;
      cap_vld_q    <= 1'b0;
      stall_q      <= 1'b0;
      rbuf_q       <= 32'h0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      ls_done_wr_q <= 1'b0;
      if_data_q    <= 32'h0;
      ls_rdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      iss_q        <= iss_d;
      cap_q        <= cap_d;
      cap_vld_q    <= cap_vld_d;
      stall_q      <= !rdy_in;
      rbuf_q       <= rbuf_d;
      if_done_q    <= if_done_d;
      ls_done_q    <= ls_done_d;
      ls_done_wr_q <= ls_done_wr_d;
      if_data_q    <= if_data_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a byte RAM model (registered read, one-cycle latency,
// garbage on mem_din while the bus is frozen), a table of load/store vectors
// with hand-computed data and latencies, and hand-written sequences for
// fetch addressing, priority, stall re-issue, flush and reset mid-store.
module tb_mem_ctrl;
  localparam int AW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic          clear_in;
  logic          if_valid_in;
  logic [AW-1:0] if_addr_in;
  logic          if_done_out;
  logic [31:0]   if_data_out;
  logic          ls_valid_in;
  logic          ls_wr_in;
  logic [1:0]    ls_size_in;
  logic [AW-1:0] ls_addr_in;
  logic [31:0]   ls_wdata_in;
  logic          ls_done_out;
  logic [31:0]   ls_rdata_out;
  logic [1:0]    dbg_state_out;

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .clear_in(clear_in),
    .if_valid_in(if_valid_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .ls_valid_in(ls_valid_in), .ls_wr_in(ls_wr_in), .ls_size_in(ls_size_in),
    .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in),
    .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out),
    .dbg_state_out(dbg_state_out)
  );

  // ---------------- RAM model ----------------
  logic [7:0] ram [0:1023];
  logic       pre_we = 1'b0;
  logic [9:0] pre_a  = 10'd0;
  logic [7:0] pre_d  = 8'd0;

  always @(posedge clk_in) begin
    if (pre_we)      ram[pre_a] <= pre_d;
    else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= rdy_in ? ram[mem_a[9:0]] : 8'hEE;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    tick;
    pre_we = 1'b0;
  endtask

  // Counts cycles from the accept edge (cycle 0) until the chosen done pulse.
  task automatic wait_done(input logic want_if, inout int cyc);
    while (cyc < 40 && !(want_if ? if_done_out : ls_done_out)) begin
      tick;
      cyc++;
    end
  endtask

  task automatic run_ls(input vec_t v);
    int cyc;
    logic [31:0] exp;
    if (!v.wr) exp_q.push_back(v.exp_rdata);
    ls_valid_in = 1'b1; ls_wr_in = v.wr; ls_size_in = v.size;
    ls_addr_in = v.addr; ls_wdata_in = v.wdata;
    cyc = 0;
    wait_done(1'b0, cyc);
    check("ls_latency", 32'(cyc), 32'(v.exp_cyc));
    if (!v.wr) begin
      exp = exp_q.pop_front();
      check("ls_rdata", ls_rdata_out, exp);
    end
    ls_valid_in = 1'b0;
    tick;
    check("ls_done_one_cycle", {31'b0, ls_done_out}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int cyc;
    int ls_cyc;
    int if_cyc;
    int both;
    vec_t v;

    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    if_valid_in = 1'b0; if_addr_in = '0;
    ls_valid_in = 1'b0; ls_wr_in = 1'b0; ls_size_in = 2'd0;
    ls_addr_in = '0; ls_wdata_in = 32'h0;

    vecs[0] = '{1'b1, 2'd1, 32'h0000_01FE, 32'hA1B2_C3D4, 32'h0,          3};
    vecs[1] = '{1'b0, 2'd0, 32'h0000_01FF, 32'h0,         32'h0000_00C3, 3};
    vecs[2] = '{1'b0, 2'd1, 32'h0000_01FE, 32'h0,         32'h0000_C3D4, 4};
    vecs[3] = '{1'b1, 2'd2, 32'h0000_0300, 32'h1122_3344, 32'h0,          5};
    vecs[4] = '{1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h1122_3344, 6};
    vecs[5] = '{1'b0, 2'd3, 32'h0000_0300, 32'h0,         32'h1122_3344, 6};
    vecs[6] = '{1'b1, 2'd0, 32'h0000_0302, 32'hFFFF_FF99, 32'h0,          2};
    vecs[7] = '{1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h1199_3344, 6};
    vecs[8] = '{1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'h12EF_CDAB, 6};
    vecs[9] = '{1'b0, 2'd1, 32'h0003_0010, 32'h0,         32'h0000_6677, 4};

    // Preload under reset.
    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h00); poke(10'h103, 8'h00);
    poke(10'h200, 8'h5A); poke(10'h201, 8'h6B); poke(10'h202, 8'h7C); poke(10'h203, 8'h8D);
    poke(10'h3FE, 8'hAB); poke(10'h3FF, 8'hCD); poke(10'h000, 8'hEF); poke(10'h001, 8'h12);
    poke(10'h010, 8'h77); poke(10'h011, 8'h66);
    for (int i = 0; i < 4; i++) begin
      poke(10'h340 + 10'(i), 8'h00);
      poke(10'h380 + 10'(i), 8'h00);
    end
    tick;
    rst_in = 1'b0;

    // Reset state.
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_wr_dout", {23'b0, mem_wr, mem_dout}, 32'h0);
    check("rst_done", {30'b0, if_done_out, ls_done_out}, 32'h0);
    check("rst_if_data", if_data_out, 32'h0);
    check("rst_ls_rdata", ls_rdata_out, 32'h0);
    check("rst_state", {30'b0, dbg_state_out}, 32'h0);

    // Word fetch with per-cycle address check.
    if_valid_in = 1'b1; if_addr_in = 32'h100;
    cyc = 0;
    while (cyc < 40 && !if_done_out) begin
      tick;
      cyc++;
      if (cyc >= 1 && cyc <= 4) begin
        check("fetch_addr", mem_a, 32'h100 + 32'(cyc - 1));
        check("fetch_wr", {31'b0, mem_wr}, 32'h0);
      end
      if (cyc == 5) check("fetch_idle_addr", mem_a, 32'h0);
    end
    check("fetch_latency", 32'(cyc), 32'd6);
    check("fetch_data", if_data_out, 32'h0000_0513);
    if_valid_in = 1'b0;
    tick;
    check("fetch_done_one_cycle", {31'b0, if_done_out}, 32'h0);

    // Table-driven loads/stores.
    for (int i = 0; i < 10; i++) run_ls(vecs[i]);
    check("ram_1fe", {24'b0, ram[10'h1FE]}, 32'hD4);
    check("ram_1ff", {24'b0, ram[10'h1FF]}, 32'hC3);
    check("ram_200_untouched", {24'b0, ram[10'h200]}, 32'h5A);
    check("ram_302", {24'b0, ram[10'h302]}, 32'h99);

    // Priority: both requests in the same IDLE cycle.
    ls_valid_in = 1'b1; ls_wr_in = 1'b0; ls_size_in = 2'd2; ls_addr_in = 32'h300;
    if_valid_in = 1'b1; if_addr_in = 32'h100;
    cyc = 0; ls_cyc = 0; if_cyc = 0; both = 0;
    while (cyc < 40 && if_cyc == 0) begin
      tick;
      cyc++;
      if (if_done_out && ls_done_out) both++;
      if (ls_done_out) begin
        ls_cyc = cyc;
        check("prio_ls_data", ls_rdata_out, 32'h1199_3344);
        ls_valid_in = 1'b0;
      end
      if (if_done_out) begin
        if_cyc = cyc;
        check("prio_if_data", if_data_out, 32'h0000_0513);
        if_valid_in = 1'b0;
      end
    end
    check("prio_ls_cycle", 32'(ls_cyc), 32'd6);
    check("prio_if_cycle", 32'(if_cyc), 32'd12);
    check("prio_never_both", 32'(both), 32'd0);
    tick;

    // Stall: word fetch of 0x200, rdy_in low in cycles 3..7.
    if_valid_in = 1'b1; if_addr_in = 32'h200;
    tick; tick; tick;
    rdy_in = 1'b0;
    #1;
    check("stall_addr_c3", mem_a, 32'h202);
    check("stall_wr_c3", {31'b0, mem_wr}, 32'h0);
    for (int c = 4; c <= 7; c++) begin
      tick;
      check("stall_addr_hold", mem_a, 32'h202);
      check("stall_state_hold", {30'b0, dbg_state_out}, 32'd1);
    end
    tick;
    rdy_in = 1'b1;
    #1;
    check("stall_reissue_addr", mem_a, 32'h201);
    cyc = 8;
    wait_done(1'b1, cyc);
    check("stall_latency", 32'(cyc), 32'd12);
    check("stall_data", if_data_out, 32'h8D7C_6B5A);
    if_valid_in = 1'b0;
    tick;

    // Flush in cycle 3 of a fetch.
    if_valid_in = 1'b1; if_addr_in = 32'h100;
    tick; tick; tick;
    clear_in = 1'b1; if_valid_in = 1'b0;
    tick;
    clear_in = 1'b0;
    check("flush_idle", {30'b0, dbg_state_out}, 32'd0);
    both = 0;
    for (int c = 0; c < 10; c++) begin
      if (if_done_out) both++;
      tick;
    end
    check("flush_no_done", 32'(both), 32'd0);

    // Flush coinciding with the fetch done pulse hides it.
    if_valid_in = 1'b1; if_addr_in = 32'h100;
    for (int c = 0; c < 6; c++) tick;
    clear_in = 1'b1; if_valid_in = 1'b0;
    #1;
    check("flush_hides_if_done", {31'b0, if_done_out}, 32'h0);
    tick;
    clear_in = 1'b0;

    // Flush held through a word store: store still completes.
    ls_valid_in = 1'b1; ls_wr_in = 1'b1; ls_size_in = 2'd2;
    ls_addr_in = 32'h340; ls_wdata_in = 32'hCAFE_F00D;
    tick; tick;
    clear_in = 1'b1;
    cyc = 2;
    wait_done(1'b0, cyc);
    check("flush_store_latency", 32'(cyc), 32'd5);
    clear_in = 1'b0; ls_valid_in = 1'b0;
    tick;
    check("flush_store_ram", {ram[10'h343], ram[10'h342], ram[10'h341], ram[10'h340]},
          32'hCAFE_F00D);

    // Reset in cycle 2 of a word store.
    ls_valid_in = 1'b1; ls_wr_in = 1'b1; ls_size_in = 2'd2;
    ls_addr_in = 32'h380; ls_wdata_in = 32'hDEAD_BEEF;
    tick; tick;
    rst_in = 1'b1;
    #1;
    check("rst_mid_wr_masked", {31'b0, mem_wr}, 32'h0);
    tick;
    rst_in = 1'b0; ls_valid_in = 1'b0;
    check("rst_mid_bus", {mem_a[22:0], mem_wr, mem_dout}, 32'h0);
    check("rst_mid_state", {29'b0, dbg_state_out, ls_done_out}, 32'h0);
    check("rst_mid_data", ls_rdata_out | if_data_out, 32'h0);
    tick;
    check("rst_mid_ram", {16'b0, ram[10'h381], ram[10'h380]}, 32'h0000_00EF);
    v = '{1'b0, 2'd2, 32'h0000_0380, 32'h0, 32'h0000_00EF, 6};
    run_ls(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
